// File: rtl/calc_pkg.sv
// calc_pkg: key codes, calculator button encodings and arbiter state types
// shared by the key arbiter, the key encoder and the keypad scanner.
package calc_pkg;

    localparam logic [3:0] KEY_ADD   = 4'd10;
    localparam logic [3:0] KEY_SUB   = 4'd11;
    localparam logic [3:0] KEY_MUL   = 4'd12;
    localparam logic [3:0] KEY_DIV   = 4'd13;
    localparam logic [3:0] KEY_EQUAL = 4'd14;
    localparam logic [3:0] KEY_CLEAR = 4'd15;

    localparam logic [9:0] BTN_NONE  = 10'h000;
    localparam logic [9:0] BTN_ADD   = 10'h201;
    localparam logic [9:0] BTN_SUB   = 10'h202;
    localparam logic [9:0] BTN_MUL   = 10'h204;
    localparam logic [9:0] BTN_DIV   = 10'h208;
    localparam logic [9:0] BTN_EQUAL = 10'h300;
    localparam logic [9:0] BTN_CLEAR = 10'h380;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_KEYPAD = 1'b0,
        SRC_HOST   = 1'b1
    } key_src_t;

    // Equal and clear both finish an expression and hand the calculator back.
    function automatic logic ends_expression(input logic [3:0] key);
        return (key == KEY_EQUAL) || (key == KEY_CLEAR);
    endfunction

endpackage

// File: rtl/calc_key_encoder.sv
// calc_key_encoder: maps a 4-bit key code onto the calculator's 10-bit
// button bus (digits one-hot, operators/equal/clear as bit combinations).
module calc_key_encoder
    import calc_pkg::*;
(
    input  logic [3:0] key,
    output logic [9:0] button
);

    // Operators and control keys have fixed codes; 0-9 become a single set bit.
    always_comb begin
        button = BTN_NONE;
        case (key)
            KEY_ADD:   button = BTN_ADD;
            KEY_SUB:   button = BTN_SUB;
            KEY_MUL:   button = BTN_MUL;
            KEY_DIV:   button = BTN_DIV;
            KEY_EQUAL: button = BTN_EQUAL;
            KEY_CLEAR: button = BTN_CLEAR;
            default:   button = 10'b1 << key;
        endcase
    end

endmodule

// File: rtl/calc_key_arbiter.sv
// calc_key_arbiter: grants the calculator to the keypad or the host for one
// expression at a time and replays each accepted key as a single-cycle press
// followed by an all-zero gap. An owner that goes quiet is forcibly cleared.
module calc_key_arbiter
    import calc_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kp_valid,
    input  logic [3:0] kp_key,
    output logic       kp_ready,
    input  logic       host_valid,
    input  logic [3:0] host_key,
    output logic       host_ready,
    output logic [9:0] button,
    output logic       busy,
    output logic       locked,
    output logic       owner,
    output logic       timeout_evt
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [3:0]       key_q;
    logic [3:0]       key_next;
    key_src_t         owner_q;
    key_src_t         rr_last;
    key_src_t         take_src;
    logic             take;
    logic             expire;
    logic [TO_W-1:0]  to_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [9:0]       enc_button;

    // The encoder looks at the key about to be pressed so the button bus
    // can be registered on the same edge the FSM enters PRESS.
    calc_key_encoder u_encoder (
        .key    (key_next),
        .button (enc_button)
    );

    assign busy  = (state != ST_IDLE);
    assign owner = owner_q;

    // Next-state, handshake and arbitration decisions for the current cycle.
    always_comb begin
        state_next = state;
        key_next   = key_q;
        kp_ready   = 1'b0;
        host_ready = 1'b0;
        take       = 1'b0;
        take_src   = SRC_KEYPAD;
        expire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (locked) begin
                    kp_ready   = (owner_q == SRC_KEYPAD);
                    host_ready = (owner_q == SRC_HOST);
                end else begin
                    kp_ready   = kp_valid && (!host_valid || rr_last == SRC_HOST);
                    host_ready = host_valid && (!kp_valid || rr_last == SRC_KEYPAD);
                end
                if (kp_valid && kp_ready) begin
                    take       = 1'b1;
                    take_src   = SRC_KEYPAD;
                    key_next   = kp_key;
                    state_next = ST_PRESS;
                end else if (host_valid && host_ready) begin
                    take       = 1'b1;
                    take_src   = SRC_HOST;
                    key_next   = host_key;
                    state_next = ST_PRESS;
                end else if (locked && to_cnt == TO_LAST) begin
                    expire     = 1'b1;
                    key_next   = KEY_CLEAR;
                    state_next = ST_PRESS;
                end
            end
            ST_PRESS: begin
                state_next = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and the latched key, which is held for the whole press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            key_q <= 4'd0;
        end else begin
            state <= state_next;
            key_q <= key_next;
        end
    end

    // Registered button bus and timeout pulse; both are non-zero only in PRESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button      <= BTN_NONE;
            timeout_evt <= 1'b0;
        end else begin
            button      <= (take || expire) ? enc_button : BTN_NONE;
            timeout_evt <= expire;
        end
    end

    // Expression ownership: taken by the first unlocked transfer, dropped at
    // the end of an equal/clear press. Reset leaves the keypad favoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked  <= 1'b0;
            owner_q <= SRC_KEYPAD;
            rr_last <= SRC_HOST;
        end else if (take && !locked) begin
            locked  <= 1'b1;
            owner_q <= take_src;
            rr_last <= take_src;
        end else if (state == ST_PRESS && ends_expression(key_q)) begin
            locked  <= 1'b0;
        end
    end

    // Owner inactivity counter: only IDLE cycles without an owner key count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!locked || take || expire) begin
            to_cnt <= '0;
        end else if (state == ST_IDLE) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Gap length counter, restarted every time the FSM enters GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
        end else begin
            gap_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_calc_key_arbiter.sv
// tb_calc_key_arbiter: directed scenarios for arbitration, timeout and reset,
// plus a randomized run compared cycle by cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_calc_key_arbiter;

    localparam int GAP = 2;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kp_valid = 1'b0;
    logic [3:0] kp_key = 4'd0;
    logic       host_valid = 1'b0;
    logic [3:0] host_key = 4'd0;
    logic       kp_ready;
    logic       host_ready;
    logic [9:0] button;
    logic       busy;
    logic       locked;
    logic       owner;
    logic       timeout_evt;

    int checks = 0;
    int errors = 0;
    int tcyc = 0;

    int         log_cyc[$];
    logic [9:0] log_btn[$];
    int         evt_count = 0;
    int         lock_violations = 0;

    calc_key_arbiter #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .kp_valid    (kp_valid),
        .kp_key      (kp_key),
        .kp_ready    (kp_ready),
        .host_valid  (host_valid),
        .host_key    (host_key),
        .host_ready  (host_ready),
        .button      (button),
        .busy        (busy),
        .locked      (locked),
        .owner       (owner),
        .timeout_evt (timeout_evt)
    );

    wire [15:0] dut_vec = {kp_ready, host_ready, button, busy, locked, owner, timeout_evt};

    always #5 clk = ~clk;

    // Cycle index; a cycle runs from one rising edge to the next.
    always @(posedge clk) tcyc++;

    // Press log, timeout pulse count and non-owner grant watch.
    always @(negedge clk) begin
        if (button != 10'd0) begin
            log_cyc.push_back(tcyc);
            log_btn.push_back(button);
        end
        if (timeout_evt) evt_count++;
        if (locked && (owner ? kp_ready : host_ready)) lock_violations++;
    end

    // Reference model: tracks the next cycle a key may be accepted, when the
    // scheduled press happens, who owns the expression and how long the owner
    // has been quiet, all as cycle arithmetic.
    int         m_cyc = 0;
    int         m_next_accept = 0;
    int         m_press_cyc = -1;
    logic [3:0] m_press_key = 4'd0;
    bit         m_press_to = 1'b0;
    bit         m_locked = 1'b0;
    bit         m_owner = 1'b0;
    bit         m_last = 1'b1;
    int         m_silent = 0;
    logic [15:0] exp_vec = 16'd0;

    function automatic logic [9:0] ref_code(input logic [3:0] k);
        case (k)
            4'd10:   return 10'h201;
            4'd11:   return 10'h202;
            4'd12:   return 10'h204;
            4'd13:   return 10'h208;
            4'd14:   return 10'h300;
            4'd15:   return 10'h380;
            default: return 10'(1 << k);
        endcase
    endfunction

    always @(negedge clk) begin : model
        bit idle;
        bit er_kp;
        bit er_host;
        bit pressing;
        m_cyc++;
        if (!rst_n) begin
            m_locked = 0; m_owner = 0; m_last = 1; m_silent = 0;
            m_next_accept = m_cyc; m_press_cyc = -1; m_press_to = 0;
        end
        idle = (m_cyc >= m_next_accept);
        pressing = (m_cyc == m_press_cyc);
        er_kp = 0;
        er_host = 0;
        if (idle) begin
            if (m_locked) begin
                er_kp = !m_owner;
                er_host = m_owner;
            end else begin
                er_kp = kp_valid && (!host_valid || m_last);
                er_host = host_valid && (!kp_valid || !m_last);
            end
        end
        exp_vec = {er_kp, er_host, pressing ? ref_code(m_press_key) : 10'd0,
                   !idle, m_locked, m_owner, pressing && m_press_to};
        if (rst_n) begin
            if (pressing && m_press_key >= 4'd14) begin
                m_locked = 0;
                m_silent = 0;
            end
            if (idle && ((kp_valid && er_kp) || (host_valid && er_host))) begin
                m_press_cyc = m_cyc + 1;
                m_press_key = (kp_valid && er_kp) ? kp_key : host_key;
                m_press_to = 0;
                m_next_accept = m_cyc + 2 + GAP;
                m_silent = 0;
                if (!m_locked) begin
                    m_locked = 1;
                    m_owner = !(kp_valid && er_kp);
                    m_last = m_owner;
                end
            end else if (idle && m_locked) begin
                if (m_silent == TMO - 1) begin
                    m_press_cyc = m_cyc + 1;
                    m_press_key = 4'd15;
                    m_press_to = 1;
                    m_next_accept = m_cyc + 2 + GAP;
                    m_silent = 0;
                end else begin
                    m_silent++;
                end
            end
        end
    end

    // Behavioural calculator fed from the press log (integer arithmetic).
    function automatic longint calc_result();
        longint acc = 0;
        longint lhs = 0;
        logic [9:0] op = 10'd0;
        logic [9:0] b;
        foreach (log_btn[i]) begin
            b = log_btn[i];
            if (b[9:8] == 2'b00) begin
                for (int j = 0; j < 10; j++) if (b[j]) acc = acc * 10 + j;
            end else if (b == 10'h300) begin
                case (op)
                    10'h201: acc = lhs + acc;
                    10'h202: acc = lhs - acc;
                    10'h204: acc = lhs * acc;
                    10'h208: acc = (acc != 0) ? lhs / acc : 0;
                    default: acc = acc;
                endcase
                op = 10'd0;
            end else if (b == 10'h380) begin
                acc = 0; lhs = 0; op = 10'd0;
            end else begin
                lhs = acc; acc = 0; op = b;
            end
        end
        return acc;
    endfunction

    function automatic logic [9:0] log_at(input int i);
        return (i < log_btn.size()) ? log_btn[i] : 10'h3ff;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < log_cyc.size()) ? log_cyc[i] : -1000;
    endfunction

    task automatic clear_log();
        log_cyc.delete();
        log_btn.delete();
        evt_count = 0;
        lock_violations = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        kp_valid = 0;
        host_valid = 0;
        rst_n = 0;
        idle_cycles(2);
        rst_n = 1;
    endtask

    // Presents one key and holds valid until it is accepted or the budget runs out.
    task automatic send(input bit src, input logic [3:0] key, input int budget, output int acc_cyc);
        int waited = 0;
        bit done = 0;
        acc_cyc = -1;
        if (src) begin host_valid = 1; host_key = key; end
        else begin kp_valid = 1; kp_key = key; end
        while (!done) begin
            @(negedge clk);
            if (src ? host_ready : kp_ready) begin
                done = 1;
                acc_cyc = tcyc;
            end
            @(posedge clk); #1;
            if (!done) begin
                waited++;
                if (waited >= budget) done = 1;
            end
        end
        checks++;
        if (acc_cyc < 0) begin
            errors++;
            $display("[TB] FAIL send_accept src=%0d key=%0d: not accepted after %0d cycles, required acceptance", src, key, waited);
        end
        if (src) host_valid = 0; else kp_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        kp_valid = 0;
        host_valid = 0;
        @(negedge clk);
        checks++;
        if ({button, busy, locked, owner, timeout_evt} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, expected %h", {button, busy, locked, owner, timeout_evt}, 14'd0);
        end
        checks++;
        if ({kp_ready, host_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ready_idle: got %b, expected %b", {kp_ready, host_ready}, 2'b00);
        end
        @(posedge clk); #1;
        rst_n = 1;
        kp_valid = 1; kp_key = 4'd1;
        host_valid = 1; host_key = 4'd2;
        @(negedge clk);
        checks++;
        if ({kp_ready, host_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_rr_pointer: got %b, expected %b", {kp_ready, host_ready}, 2'b10);
        end
        #1;
        kp_valid = 0;
        host_valid = 0;
        @(posedge clk); #1;
        checks++;
        if ({busy, locked} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_no_transfer: got %b, expected %b", {busy, locked}, 2'b00);
        end
    endtask

    task automatic test_sequence();
        logic [9:0] exp_seq [4] = '{10'h008, 10'h201, 10'h010, 10'h300};
        int a0, a1, a2, a3;
        do_reset();
        clear_log();
        send(0, 4'd3, 20, a0);
        send(0, 4'd10, 20, a1);
        send(0, 4'd4, 20, a2);
        send(0, 4'd14, 20, a3);
        idle_cycles(GAP + 3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_at(i) !== exp_seq[i]) begin
                errors++;
                $display("[TB] FAIL seq_button%0d: got %h, expected %h", i, log_at(i), exp_seq[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cyc_at(i + 1) - cyc_at(i) != GAP + 2) begin
                errors++;
                $display("[TB] FAIL seq_spacing%0d: got %0d cycles, expected %0d", i, cyc_at(i + 1) - cyc_at(i), GAP + 2);
            end
        end
        checks++;
        if (cyc_at(0) != a0 + 1) begin
            errors++;
            $display("[TB] FAIL seq_latency: got press cycle %0d, expected %0d", cyc_at(0), a0 + 1);
        end
        checks++;
        if (a1 != a0 + 2 + GAP) begin
            errors++;
            $display("[TB] FAIL seq_next_accept: got %0d, expected %0d", a1, a0 + 2 + GAP);
        end
        checks++;
        if (calc_result() != 7) begin
            errors++;
            $display("[TB] FAIL seq_result: got %0d, expected %0d", calc_result(), 7);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL seq_unlock: got %b, expected %b", locked, 1'b0);
        end
    endtask

    task automatic test_arbitration();
        int k0, k1, h0;
        do_reset();
        clear_log();
        fork
            begin
                send(0, 4'd2, 20, k0);
                send(0, 4'd14, 20, k1);
            end
            begin
                send(1, 4'd5, 40, h0);
            end
        join
        idle_cycles(GAP + 3);
        checks++;
        if ({log_at(0), log_at(1), log_at(2)} !== {10'h004, 10'h300, 10'h020}) begin
            errors++;
            $display("[TB] FAIL arb_order: got %h %h %h, expected 004 300 020", log_at(0), log_at(1), log_at(2));
        end
        checks++;
        if (h0 != k1 + 2 + GAP) begin
            errors++;
            $display("[TB] FAIL arb_host_grant: got cycle %0d, expected %0d", h0, k1 + 2 + GAP);
        end
        checks++;
        if (lock_violations != 0) begin
            errors++;
            $display("[TB] FAIL arb_stall: got %0d non-owner ready cycles, expected 0", lock_violations);
        end
        checks++;
        if ({locked, owner} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL arb_host_owns: got %b, expected %b", {locked, owner}, 2'b11);
        end
    endtask

    task automatic test_timeout();
        int a;
        int found = -1;
        logic [9:0] btn_at = 10'd0;
        do_reset();
        clear_log();
        send(0, 4'd6, 20, a);
        for (int i = 0; i < GAP + TMO + 12 && found < 0; i++) begin
            @(negedge clk);
            if (timeout_evt) begin
                found = tcyc;
                btn_at = button;
            end
            @(posedge clk); #1;
        end
        idle_cycles(GAP + 2);
        checks++;
        if (found != a + 2 + GAP + TMO) begin
            errors++;
            $display("[TB] FAIL timeout_cycle: got %0d, expected %0d", found, a + 2 + GAP + TMO);
        end
        checks++;
        if (btn_at !== 10'h380) begin
            errors++;
            $display("[TB] FAIL timeout_button: got %h, expected %h", btn_at, 10'h380);
        end
        checks++;
        if (evt_count != 1) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: got %0d cycles, expected %0d", evt_count, 1);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_unlock: got %b, expected %b", locked, 1'b0);
        end
        checks++;
        if (calc_result() != 0 || log_btn.size() != 2) begin
            errors++;
            $display("[TB] FAIL timeout_result: got result %0d presses %0d, expected 0 and 2", calc_result(), log_btn.size());
        end
    endtask

    task automatic test_expiry_race();
        int a, b, expiry;
        do_reset();
        clear_log();
        send(0, 4'd6, 20, a);
        expiry = a + 1 + GAP + TMO;
        while (tcyc < expiry) begin
            @(posedge clk); #1;
        end
        send(0, 4'd7, 5, b);
        idle_cycles(GAP + 3);
        checks++;
        if (b != expiry) begin
            errors++;
            $display("[TB] FAIL race_accept: got cycle %0d, expected %0d", b, expiry);
        end
        checks++;
        if (evt_count != 0) begin
            errors++;
            $display("[TB] FAIL race_no_timeout: got %0d pulses, expected 0", evt_count);
        end
        checks++;
        if (log_at(1) !== 10'h080 || cyc_at(1) != expiry + 1) begin
            errors++;
            $display("[TB] FAIL race_press: got %h at %0d, expected 080 at %0d", log_at(1), cyc_at(1), expiry + 1);
        end
        checks++;
        if ({locked, owner} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL race_lock: got %b, expected %b", {locked, owner}, 2'b10);
        end
    endtask

    task automatic test_reset_mid_press();
        int a, b, c0;
        do_reset();
        clear_log();
        send(0, 4'd2, 20, a);
        checks++;
        if (button !== 10'h004) begin
            errors++;
            $display("[TB] FAIL midrst_press: got %h, expected %h", button, 10'h004);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({button, busy, locked, timeout_evt} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL midrst_clear: got %h, expected %h", {button, busy, locked, timeout_evt}, 13'd0);
        end
        @(posedge clk); #1;
        rst_n = 1;
        c0 = tcyc;
        send(0, 4'd9, 5, b);
        checks++;
        if (b != c0) begin
            errors++;
            $display("[TB] FAIL midrst_accept: got cycle %0d, expected %0d", b, c0);
        end
        checks++;
        if ({button, locked, owner} !== {10'h200, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midrst_next_press: got %h, expected %h", {button, locked, owner}, {10'h200, 1'b1, 1'b0});
        end
    endtask

    task automatic test_host_clear();
        int h0, h1, h2, k0;
        do_reset();
        clear_log();
        send(1, 4'd1, 20, h0);
        fork
            begin
                send(1, 4'd12, 20, h1);
                send(1, 4'd15, 20, h2);
            end
            begin
                send(0, 4'd3, 60, k0);
            end
        join
        idle_cycles(GAP + 3);
        checks++;
        if ({log_at(0), log_at(1), log_at(2), log_at(3)} !== {10'h002, 10'h204, 10'h380, 10'h008}) begin
            errors++;
            $display("[TB] FAIL hclr_order: got %h %h %h %h, expected 002 204 380 008", log_at(0), log_at(1), log_at(2), log_at(3));
        end
        checks++;
        if (k0 != h2 + 2 + GAP) begin
            errors++;
            $display("[TB] FAIL hclr_kp_grant: got cycle %0d, expected %0d", k0, h2 + 2 + GAP);
        end
        checks++;
        if (lock_violations != 0) begin
            errors++;
            $display("[TB] FAIL hclr_stall: got %0d non-owner ready cycles, expected 0", lock_violations);
        end
        checks++;
        if ({locked, owner} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL hclr_kp_owns: got %b, expected %b", {locked, owner}, 2'b10);
        end
    endtask

    task automatic test_random();
        bit quiet;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            quiet = (i % 120) >= 90;
            kp_valid = !quiet && ($urandom_range(0, 3) == 0);
            kp_key = 4'($urandom_range(0, 15));
            host_valid = !quiet && ($urandom_range(0, 3) == 0);
            host_key = 4'($urandom_range(0, 15));
            @(negedge clk); #1;
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d {kr,hr,btn,busy,lk,own,evt}: got %h, expected %h", i, dut_vec, exp_vec);
            end
            @(posedge clk); #1;
        end
        kp_valid = 0;
        host_valid = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_sequence();
        test_arbitration();
        test_timeout();
        test_expiry_race();
        test_reset_mid_press();
        test_host_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
